// File: rtl/sound_latch_irq.sv
// 68K-to-Z80 sound command latch with full flag, plus the Z80 periodic maskable interrupt.
// One clk_sys from strobe edge to latch/flag update; no backpressure, one capture per bus cycle.
module sound_latch_irq #(
  parameter int IRQ_DIV = 512,
  parameter int CNT_W   = 10
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        z80_cen,
  input  logic [15:0] m68k_din,
  input  logic        m68k_rw,
  input  logic        m68k_lds_n,
  input  logic        sound_latch_cs,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_latch_r_cs,
  input  logic        z80_latch_clr_cs,
  input  logic        M1_n,
  input  logic        IORQ_n,
  input  logic        irq_en,
  output logic [7:0]  latch_dout,
  output logic        latch_full,
  output logic        z80_int_n
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRQ_DIV - 1);

  logic wr_req, rd_req, clr_req, ack;
  logic wr_req_q, rd_req_q, clr_req_q, ack_q;
  logic armed;
  logic wr_edge, rd_edge, clr_edge, ack_edge;
  logic [CNT_W-1:0] cnt;
  logic count_en, expire;
  logic unused_din_hi;

  assign wr_req  = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
  assign rd_req  = z80_latch_r_cs & ~z80_rd_n;
  assign clr_req = z80_latch_clr_cs & ~z80_wr_n;
  assign ack     = ~M1_n & ~IORQ_n;

  // armed stays low for the first clock after reset so a strobe held across
  // release only reloads the edge registers instead of firing an event.
  assign wr_edge  = armed & wr_req & ~wr_req_q;
  assign rd_edge  = armed & rd_req & ~rd_req_q;
  assign clr_edge = armed & clr_req & ~clr_req_q;
  assign ack_edge = armed & ack & ~ack_q;

  assign count_en = z80_cen & irq_en;
  assign expire   = count_en & (cnt == CNT_LAST);

  assign unused_din_hi = ^m68k_din[15:8];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      clr_req_q <= 1'b0;
      ack_q     <= 1'b0;
      armed     <= 1'b0;
    end else begin
      wr_req_q  <= wr_req;
      rd_req_q  <= rd_req;
      clr_req_q <= clr_req;
      ack_q     <= ack;
      armed     <= 1'b1;
    end
  end

  // Priority: 68K write over clear over read.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      latch_dout <= 8'h00;
      latch_full <= 1'b0;
    end else if (wr_edge) begin
      latch_dout <= m68k_din[7:0];
      latch_full <= 1'b1;
    end else if (clr_edge) begin
      latch_dout <= 8'h00;
      latch_full <= 1'b0;
    end else if (rd_edge) begin
      latch_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= expire ? '0 : cnt + 1'b1;
    end
  end

  // An expiry beats a same-edge acknowledge; a pending interrupt is never queued twice.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      z80_int_n <= 1'b1;
    end else if (expire) begin
      z80_int_n <= 1'b0;
    end else if (ack_edge) begin
      z80_int_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sound_latch_irq.sv
// Bench for sound_latch_irq: table-driven latch vectors, scripted IRQ/reset sequences,
// expectations queued at drive time and popped one clock later.
module tb_sound_latch_irq;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        z80_cen;
  logic [15:0] m68k_din;
  logic        m68k_rw, m68k_lds_n, sound_latch_cs;
  logic        z80_rd_n, z80_wr_n, z80_latch_r_cs, z80_latch_clr_cs;
  logic        M1_n, IORQ_n, irq_en;
  logic [7:0]  latch_dout;
  logic        latch_full, z80_int_n;

  sound_latch_irq #(.IRQ_DIV(4), .CNT_W(2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .z80_cen(z80_cen), .m68k_din(m68k_din),
    .m68k_rw(m68k_rw), .m68k_lds_n(m68k_lds_n), .sound_latch_cs(sound_latch_cs),
    .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n), .z80_latch_r_cs(z80_latch_r_cs),
    .z80_latch_clr_cs(z80_latch_clr_cs), .M1_n(M1_n), .IORQ_n(IORQ_n), .irq_en(irq_en),
    .latch_dout(latch_dout), .latch_full(latch_full), .z80_int_n(z80_int_n)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] dout;
    logic       full;
    logic       int_n;
  } exp_t;

  typedef struct {
    logic        cs, rw, lds_n;
    logic [15:0] din;
    logic        rcs, rd_n, ccs, wr_n;
    logic [7:0]  e_dout;
    logic        e_full;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic [7:0] l_dout = 8'h00;
  logic       l_full = 1'b0;
  int         m_cnt = 0;
  logic       m_int = 1'b1;
  logic       m_ack_prev = 1'b0;
  int         gcyc = 0;

  function automatic vec_t v(input logic cs, input logic rw, input logic lds_n,
                             input logic [15:0] din, input logic rcs, input logic rd_n,
                             input logic ccs, input logic wr_n,
                             input logic [7:0] e_dout, input logic e_full);
    vec_t r;
    r.cs = cs; r.rw = rw; r.lds_n = lds_n; r.din = din;
    r.rcs = rcs; r.rd_n = rd_n; r.ccs = ccs; r.wr_n = wr_n;
    r.e_dout = e_dout; r.e_full = e_full;
    return r;
  endfunction

  task automatic check_out();
    exp_t  e;
    string nm;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (latch_dout !== e.dout || latch_full !== e.full || z80_int_n !== e.int_n) begin
        n_fail++;
        $display("FAIL %s: got dout=%h full=%b int_n=%b, expected dout=%h full=%b int_n=%b",
                 nm, latch_dout, latch_full, z80_int_n, e.dout, e.full, e.int_n);
      end
    end
  endtask

  task automatic push_exp(input string nm, input logic [7:0] ed, input logic ef, input logic ei);
    exp_t e;
    e.dout = ed; e.full = ef; e.int_n = ei;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm, input logic [7:0] ed, input logic ef, input logic ei);
    push_exp(nm, ed, ef, ei);
    @(posedge clk_sys);
    #1;
    check_out();
  endtask

  task automatic idle_bus();
    sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1; m68k_din = 16'h0000;
    z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1; z80_latch_clr_cs = 1'b0; z80_wr_n = 1'b1;
  endtask

  // One clock of IRQ stimulus; expected INT derives from the counting/ack rules.
  task automatic irq_cycle(input string nm, input logic cen, input logic en, input logic ack);
    logic ack_edge, expire;
    z80_cen = cen; irq_en = en; M1_n = ~ack; IORQ_n = ~ack;
    ack_edge = ack & ~m_ack_prev;
    m_ack_prev = ack;
    expire = 1'b0;
    if (cen && en) begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        expire = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    if (expire) m_int = 1'b0;
    else if (ack_edge) m_int = 1'b1;
    step(nm, l_dout, l_full, m_int);
  endtask

  // ack_at >= 0: ack held on cycles ack_at and ack_at+1; -1: no ack;
  // -2: ack raised for one clock exactly on the next expiry edge.
  task automatic irq_run(input string nm, input int n, input logic en, input int ack_at);
    logic cen, ack, fired;
    fired = 1'b0;
    for (int i = 0; i < n; i++) begin
      cen = (gcyc % 3 == 2);
      if (ack_at >= 0) ack = (i == ack_at || i == ack_at + 1);
      else if (ack_at == -2) ack = !fired && cen && en && (m_cnt == 3);
      else ack = 1'b0;
      if (ack && ack_at == -2) fired = 1'b1;
      irq_cycle($sformatf("%s[%0d]", nm, i), cen, en, ack);
      gcyc++;
    end
    z80_cen = 1'b0; M1_n = 1'b1; IORQ_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    z80_cen = 1'b0; irq_en = 1'b0; M1_n = 1'b1; IORQ_n = 1'b1;
    idle_bus();

    //            cs rw ld din       rcs rd ccs wr   dout  full
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 16'hA55A, 0, 1, 0, 1, 8'h5A, 1));
    tbl.push_back(v(1, 0, 0, 16'h1234, 0, 1, 0, 1, 8'h5A, 1));
    tbl.push_back(v(1, 0, 0, 16'hA55A, 0, 1, 0, 1, 8'h5A, 1));
    tbl.push_back(v(1, 0, 0, 16'hA55A, 0, 1, 0, 1, 8'h5A, 1));
    tbl.push_back(v(1, 0, 0, 16'hA55A, 0, 1, 0, 1, 8'h5A, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h5A, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 1, 0, 0, 1, 8'h5A, 0));
    tbl.push_back(v(0, 1, 1, 16'h0000, 1, 0, 0, 1, 8'h5A, 0));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 16'h0077, 0, 1, 0, 1, 8'h77, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h77, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 1, 0, 0, 1, 8'h77, 0));
    tbl.push_back(v(1, 0, 0, 16'h0011, 1, 0, 0, 1, 8'h11, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h11, 1));
    tbl.push_back(v(1, 0, 0, 16'h0033, 0, 1, 1, 0, 8'h33, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h33, 1));
    tbl.push_back(v(1, 0, 0, 16'h0044, 1, 0, 0, 1, 8'h44, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h44, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 1, 0, 1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h00, 0));
    tbl.push_back(v(1, 1, 0, 16'h00EE, 0, 1, 0, 1, 8'h00, 0));
    tbl.push_back(v(1, 0, 1, 16'h00EE, 0, 1, 0, 1, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 16'h00EE, 0, 1, 0, 1, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 0, 1, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 16'hBEEF, 0, 1, 0, 1, 8'hEF, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 1, 1, 1, 8'hEF, 1));
    tbl.push_back(v(0, 1, 1, 16'h0000, 0, 0, 0, 1, 8'hEF, 1));

    #12;
    push_exp("reset_values", 8'h00, 1'b0, 1'b1);
    check_out();
    reset_n = 1'b1;
    step("first_clock", 8'h00, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      sound_latch_cs = tbl[i].cs; m68k_rw = tbl[i].rw; m68k_lds_n = tbl[i].lds_n;
      m68k_din = tbl[i].din;
      z80_latch_r_cs = tbl[i].rcs; z80_rd_n = tbl[i].rd_n;
      z80_latch_clr_cs = tbl[i].ccs; z80_wr_n = tbl[i].wr_n;
      l_dout = tbl[i].e_dout; l_full = tbl[i].e_full;
      step($sformatf("vec%0d", i), l_dout, l_full, 1'b1);
    end
    idle_bus();

    irq_run("irq_first",   12, 1'b1, -1);
    irq_run("irq_ack",     14, 1'b1,  1);
    irq_run("irq_pend",    40, 1'b1, -1);
    irq_run("irq_ack2",     3, 1'b1,  0);
    irq_run("irq_coll",    14, 1'b1, -2);
    irq_run("irq_en_off",  15, 1'b0, -1);
    irq_run("irq_off_ack", 15, 1'b0,  2);
    irq_run("irq_resume",  15, 1'b1, -1);

    // Write in flight with INT pending, then asynchronous reset.
    sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_din = 16'h005A;
    l_dout = 8'h5A; l_full = 1'b1;
    step("pre_reset_write", l_dout, l_full, m_int);
    #2 reset_n = 1'b0;
    #1;
    push_exp("async_reset", 8'h00, 1'b0, 1'b1);
    check_out();
    m68k_din = 16'h0099;
    l_dout = 8'h00; l_full = 1'b0;
    m_cnt = 0; m_int = 1'b1; m_ack_prev = 1'b0;
    #3 reset_n = 1'b1;
    step("release_held_1", 8'h00, 1'b0, 1'b1);
    step("release_held_2", 8'h00, 1'b0, 1'b1);
    idle_bus();
    step("release_drop", 8'h00, 1'b0, 1'b1);
    sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_din = 16'h0099;
    l_dout = 8'h99; l_full = 1'b1;
    step("post_reset_write", l_dout, l_full, 1'b1);
    idle_bus();
    irq_run("irq_after_rst", 13, 1'b1, -1);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d expectations unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
